// File: rtl/trig_wd_pkg.sv
// Shared constants for the trigger watchdog: FSM state codes, recovery mode codes
// and default widths.
package trig_wd_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COUNT    = 2'd1;
  localparam logic [1:0] ST_OVERRIDE = 2'd2;
  localparam logic [1:0] ST_HOLDOFF  = 2'd3;

  localparam logic MODE_PAUSE = 1'b0;
  localparam logic MODE_BSUM  = 1'b1;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_LEN_W = 16;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/wd_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module wd_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + ONE;
  end

endmodule

// File: rtl/trig_watchdog.sv
// Stuck-trigger monitor for fir_trig TOT lanes; recovers via pause_override or a
// bsum_reset pulse plus holdoff, and counts fire events.
//
// state    | meaning
// IDLE     | no unmasked channel in trigger
// COUNT    | any_trig held, run_cnt counting consecutive edges
// OVERRIDE | pause_override asserted for max(override_len,1) cycles
// HOLDOFF  | bsum_reset pulsed on first cycle, then wait out max(override_len,1) cycles
module trig_watchdog
  import trig_wd_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_CH-1:0]  tot,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic [LEN_W-1:0] max_len,
  input  logic [LEN_W-1:0] override_len,
  input  logic             mode,
  input  logic             clear_count,
  output logic             pause_override,
  output logic             bsum_reset,
  output logic [N_CH-1:0]  stuck_ch,
  output logic [CNT_W-1:0] fire_count,
  output logic             busy
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  logic [1:0]       state;
  logic [LEN_W-1:0] run_cnt;
  logic [LEN_W-1:0] ovr_cnt;
  logic [LEN_W-1:0] ovr_last;
  logic             any_trig;
  logic             in_recovery;
  logic             ovr_done;
  logic             fire;
  logic             run_inc, run_clr;
  logic             ovr_inc, ovr_clr;

  assign any_trig    = |(tot & ch_mask);
  assign in_recovery = (state == ST_OVERRIDE) || (state == ST_HOLDOFF);
  // override_len of 0 behaves as 1, so the last index is 0 in both cases
  assign ovr_last    = (override_len == '0) ? '0 : (override_len - ONE);
  assign ovr_done    = (ovr_cnt >= ovr_last);

  assign fire = enable && (state == ST_COUNT) && any_trig &&
                (max_len != '0) && (run_cnt >= (max_len - ONE));

  assign run_inc = enable && any_trig &&
                   ((state == ST_IDLE) || ((state == ST_COUNT) && !fire));
  assign run_clr = !enable || ((state == ST_COUNT) && (!any_trig || fire));

  assign ovr_inc = enable && in_recovery && !ovr_done;
  assign ovr_clr = !enable || fire || (in_recovery && ovr_done);

  wd_sat_counter #(.WIDTH(LEN_W)) u_run_cnt (
    .clk (clk),
    .rst (rst),
    .inc (run_inc),
    .clr (run_clr),
    .q   (run_cnt)
  );

  wd_sat_counter #(.WIDTH(LEN_W)) u_ovr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ovr_inc),
    .clr (ovr_clr),
    .q   (ovr_cnt)
  );

  wd_sat_counter #(.WIDTH(CNT_W)) u_fire_cnt (
    .clk (clk),
    .rst (rst),
    .inc (fire),
    .clr (clear_count),
    .q   (fire_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      pause_override <= 1'b0;
      bsum_reset     <= 1'b0;
      busy           <= 1'b0;
      stuck_ch       <= '0;
    end else if (!enable) begin
      state          <= ST_IDLE;
      pause_override <= 1'b0;
      bsum_reset     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      bsum_reset <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_trig)
            state <= ST_COUNT;
        end
        ST_COUNT: begin
          if (!any_trig) begin
            state <= ST_IDLE;
          end else if (fire) begin
            stuck_ch       <= tot & ch_mask;
            busy           <= 1'b1;
            state          <= (mode == MODE_BSUM) ? ST_HOLDOFF : ST_OVERRIDE;
            pause_override <= (mode == MODE_PAUSE);
            bsum_reset     <= (mode == MODE_BSUM);
          end
        end
        ST_OVERRIDE, ST_HOLDOFF: begin
          if (ovr_done) begin
            state          <= ST_IDLE;
            pause_override <= 1'b0;
            busy           <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_watchdog.sv
// Bench for trig_watchdog: directed table, hand-written corner sequences and a
// randomized phase, all compared against a run-length/recovery-time model.
module tb_trig_watchdog;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  tot, ch_mask;
  logic [15:0] max_len, override_len;
  logic        mode, clear_count;

  logic        pause_override, bsum_reset, busy;
  logic [3:0]  stuck_ch;
  logic [15:0] fire_count;

  logic        pause2, bsum2, busy2;
  logic [3:0]  stuck2;
  logic [1:0]  fire_count2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  trig_watchdog #(.N_CH(4), .LEN_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .tot(tot), .ch_mask(ch_mask),
    .max_len(max_len), .override_len(override_len), .mode(mode),
    .clear_count(clear_count), .pause_override(pause_override),
    .bsum_reset(bsum_reset), .stuck_ch(stuck_ch), .fire_count(fire_count),
    .busy(busy)
  );

  trig_watchdog #(.N_CH(4), .LEN_W(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .tot(tot), .ch_mask(ch_mask),
    .max_len(max_len), .override_len(override_len), .mode(mode),
    .clear_count(clear_count), .pause_override(pause2),
    .bsum_reset(bsum2), .stuck_ch(stuck2), .fire_count(fire_count2),
    .busy(busy2)
  );

  // Model: streak = consecutive enabled any_trig edges since idle,
  // rec = cycles the current recovery has been active (0 = none).
  int         m_streak, m_rec, m_cnt, m_cnt2;
  bit         m_bsum;
  logic [3:0] m_stuck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_streak = 0; m_rec = 0; m_cnt = 0; m_cnt2 = 0; m_bsum = 0; m_stuck = '0;
  endtask

  task automatic model_step();
    int  rec_len, thr;
    bit  fired;
    fired   = 0;
    rec_len = (override_len == 0) ? 1 : int'(override_len);
    thr     = (max_len < 2) ? 2 : int'(max_len);
    if (!enable) begin
      m_streak = 0;
      m_rec    = 0;
    end else if (m_rec > 0) begin
      if (m_rec >= rec_len) m_rec = 0;
      else m_rec++;
    end else if ((tot & ch_mask) != 0) begin
      m_streak++;
      if (max_len != 0 && m_streak >= thr) begin
        fired    = 1;
        m_streak = 0;
        m_rec    = 1;
        m_bsum   = mode;
        m_stuck  = tot & ch_mask;
      end
    end else begin
      m_streak = 0;
    end
    if (clear_count) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (fired) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("pause",  pause_override, (m_rec > 0) && !m_bsum);
    check("bsum",   bsum_reset,     (m_rec == 1) && m_bsum);
    check("busy",   busy,           m_rec > 0);
    check("stuck",  stuck_ch,       m_stuck);
    check("count",  fire_count,     m_cnt);
    check("count2", fire_count2,    m_cnt2);
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  tot, mask;
    logic [15:0] ml, ol;
    logic        mode;
    int          edges;
    logic        e_pause, e_bsum, e_busy;
    logic [3:0]  e_stuck;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // en tot mask ml ol mode edges | pause bsum busy stuck cnt
    vecs[0]  = '{1'b1, 4'h2, 4'hF, 16'd20, 16'd5, 1'b0, 19,  1'b0, 1'b0, 1'b0, 4'h0, 16'd0};
    vecs[1]  = '{1'b1, 4'h2, 4'hF, 16'd20, 16'd5, 1'b0, 1,   1'b1, 1'b0, 1'b1, 4'h2, 16'd1};
    vecs[2]  = '{1'b1, 4'h2, 4'hF, 16'd20, 16'd5, 1'b0, 4,   1'b1, 1'b0, 1'b1, 4'h2, 16'd1};
    vecs[3]  = '{1'b1, 4'h2, 4'hF, 16'd20, 16'd5, 1'b0, 1,   1'b0, 1'b0, 1'b0, 4'h2, 16'd1};
    vecs[4]  = '{1'b1, 4'h2, 4'hF, 16'd20, 16'd5, 1'b0, 19,  1'b0, 1'b0, 1'b0, 4'h2, 16'd1};
    vecs[5]  = '{1'b1, 4'h2, 4'hF, 16'd20, 16'd5, 1'b0, 1,   1'b1, 1'b0, 1'b1, 4'h2, 16'd2};
    vecs[6]  = '{1'b0, 4'h0, 4'hF, 16'd20, 16'd5, 1'b0, 1,   1'b0, 1'b0, 1'b0, 4'h2, 16'd2};
    vecs[7]  = '{1'b1, 4'h2, 4'hF, 16'd20, 16'd5, 1'b1, 19,  1'b0, 1'b0, 1'b0, 4'h2, 16'd2};
    vecs[8]  = '{1'b1, 4'h2, 4'hF, 16'd20, 16'd5, 1'b1, 1,   1'b0, 1'b1, 1'b1, 4'h2, 16'd3};
    vecs[9]  = '{1'b1, 4'h2, 4'hF, 16'd20, 16'd5, 1'b1, 1,   1'b0, 1'b0, 1'b1, 4'h2, 16'd3};
    vecs[10] = '{1'b1, 4'h2, 4'hF, 16'd20, 16'd5, 1'b1, 3,   1'b0, 1'b0, 1'b1, 4'h2, 16'd3};
    vecs[11] = '{1'b1, 4'h2, 4'hF, 16'd20, 16'd5, 1'b1, 1,   1'b0, 1'b0, 1'b0, 4'h2, 16'd3};
    vecs[12] = '{1'b1, 4'h2, 4'hD, 16'd20, 16'd5, 1'b0, 100, 1'b0, 1'b0, 1'b0, 4'h2, 16'd3};

    rst = 1'b1; enable = 1'b1; tot = '0; ch_mask = 4'hF;
    max_len = 16'd20; override_len = 16'd5; mode = 1'b0; clear_count = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pause", pause_override, 0);
    check("rst_bsum",  bsum_reset, 0);
    check("rst_busy",  busy, 0);
    check("rst_stuck", stuck_ch, 0);
    check("rst_count", fire_count, 0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      enable = vecs[i].en; tot = vecs[i].tot; ch_mask = vecs[i].mask;
      max_len = vecs[i].ml; override_len = vecs[i].ol; mode = vecs[i].mode;
      repeat (vecs[i].edges) tick();
      check($sformatf("vec%0d_pause", i), pause_override, vecs[i].e_pause);
      check($sformatf("vec%0d_bsum", i),  bsum_reset,     vecs[i].e_bsum);
      check($sformatf("vec%0d_busy", i),  busy,           vecs[i].e_busy);
      check($sformatf("vec%0d_stuck", i), stuck_ch,       vecs[i].e_stuck);
      check($sformatf("vec%0d_count", i), fire_count,     vecs[i].e_cnt);
    end

    // 19 high / 1 low never reaches max_len=20
    ch_mask = 4'hF; mode = 1'b0;
    for (int r = 0; r < 5; r++) begin
      tot = 4'h2;
      repeat (19) tick();
      tot = 4'h0;
      tick();
    end
    check("gap_busy", busy, 0);
    check("gap_count", fire_count, 3);

    // max_len=0 never fires; lowering it mid-run fires on the next edge
    max_len = 16'd0; tot = 4'h2;
    repeat (1000) tick();
    check("ml0_busy", busy, 0);
    check("ml0_count", fire_count, 3);
    max_len = 16'd3;
    tick();
    check("ml3_pause", pause_override, 1);
    check("ml3_count", fire_count, 4);

    // enable dropped during the third override cycle
    tick();
    tick();
    check("ovr3_pause", pause_override, 1);
    enable = 1'b0;
    tick();
    check("endrop_pause", pause_override, 0);
    check("endrop_busy",  busy, 0);
    check("endrop_count", fire_count, 4);
    check("endrop_stuck", stuck_ch, 4'h2);

    // async reset in the middle of a holdoff
    enable = 1'b1; mode = 1'b1; max_len = 16'd3;
    repeat (3) tick();
    check("hold_bsum", bsum_reset, 1);
    tick();
    check("hold_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_pause", pause_override, 0);
    check("arst_bsum",  bsum_reset, 0);
    check("arst_busy",  busy, 0);
    check("arst_stuck", stuck_ch, 0);
    check("arst_count", fire_count, 0);
    model_reset();
    tot = 4'h0;
    #2 rst = 1'b0;
    repeat (10) tick();
    check("post_rst_busy", busy, 0);

    // five fires: 16-bit count reaches 5, 2-bit count saturates at 3
    mode = 1'b0; max_len = 16'd2; override_len = 16'd1; tot = 4'h1;
    repeat (15) tick();
    check("sat_count16", fire_count, 5);
    check("sat_count2",  fire_count2, 3);
    check("sat_stuck",   stuck_ch, 4'h1);
    tot = 4'h0;
    repeat (3) tick();

    // clear_count coincident with a fire
    max_len = 16'd3; override_len = 16'd5; tot = 4'h8;
    repeat (2) tick();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    check("clr_busy",   busy, 1);
    check("clr_count",  fire_count, 0);
    check("clr_count2", fire_count2, 0);
    check("clr_stuck",  stuck_ch, 4'h8);

    // randomized phase against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        max_len      = 16'($urandom_range(0, 6));
        override_len = 16'($urandom_range(0, 4));
        mode         = 1'($urandom_range(0, 1));
        ch_mask      = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 5) == 0) tot = 4'($urandom_range(0, 15));
      enable      = ($urandom_range(0, 49) != 0);
      clear_count = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
